// File: rtl/csr_queue_pkg.sv
// csr_queue_pkg: shared types and constants for the CSR commit queue.
// Each queue slot holds the CSR address and scoreboard transaction ID of one
// speculative CSR instruction.
package csr_queue_pkg;

  localparam int CSR_ADDR_W     = 12;
  // Width of the stored transaction ID; must match the TRANS_ID_BITS parameter
  // of csr_queue and csr_queue_if.
  localparam int CSR_TRANS_ID_W = 3;

  typedef struct packed {
    logic [CSR_ADDR_W-1:0]     addr;
    logic [CSR_TRANS_ID_W-1:0] trans_id;
  } csr_entry_t;

endpackage

// File: rtl/csr_queue_if.sv
// csr_queue_if: issue-side, commit-side and status signals of the CSR queue.
// Handshake: an issue is accepted on any clock edge where valid_i and ready_o
// are both high; a pop happens on any edge where commit_i and csr_valid_o are
// both high; flush_i overrides both in the same cycle.
// With CSR_QUEUE_FULL_BYPASS_EN defined, ready_o also depends on commit_i.
interface csr_queue_if
  import csr_queue_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int DEPTH         = 4,
  parameter int TRANS_ID_BITS = 3
) ();

  logic                       flush_i;
  logic                       valid_i;
  logic [XLEN-1:0]            operand_a_i;
  logic [XLEN-1:0]            operand_b_i;
  logic [TRANS_ID_BITS-1:0]   trans_id_i;
  logic                       ready_o;
  logic [XLEN-1:0]            result_o;
  logic                       commit_i;
  logic [CSR_ADDR_W-1:0]      csr_addr_o;
  logic [TRANS_ID_BITS-1:0]   csr_trans_id_o;
  logic                       csr_valid_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  logic                       commit_err_o;

  // Issue/commit environment side.
  modport master (
    output flush_i, valid_i, operand_a_i, operand_b_i, trans_id_i, commit_i,
    input  ready_o, result_o, csr_addr_o, csr_trans_id_o, csr_valid_o,
           count_o, commit_err_o
  );

  // Queue side.
  modport slave (
    input  flush_i, valid_i, operand_a_i, operand_b_i, trans_id_i, commit_i,
    output ready_o, result_o, csr_addr_o, csr_trans_id_o, csr_valid_o,
           count_o, commit_err_o
  );

endinterface

// File: rtl/csr_queue.sv
// csr_queue: in-order queue of speculative CSR instructions, released one per
// commit pulse. Optional feature macro: CSR_QUEUE_FULL_BYPASS_EN (accept a push
// while full when the same cycle commits).
module csr_queue
  import csr_queue_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int DEPTH         = 4,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  csr_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  csr_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             commit_err;
  logic             full;
  logic             empty;
  logic             ready;
  logic             push;
  logic             pop;
  csr_entry_t       new_entry;
  csr_entry_t       head_entry;
  logic             unused_operand_b;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

`ifdef CSR_QUEUE_FULL_BYPASS_EN
  // A same-cycle commit frees the head slot, so a push can reuse it.
  assign ready = !full || bus.commit_i;
`else
  assign ready = !full;
`endif

  assign push = bus.valid_i && ready && !bus.flush_i;
  assign pop  = bus.commit_i && !empty && !bus.flush_i;

  assign new_entry.addr     = bus.operand_b_i[CSR_ADDR_W-1:0];
  assign new_entry.trans_id = bus.trans_id_i;
  assign head_entry         = mem[rd_ptr];

  // Only the low CSR_ADDR_W bits of operand_b carry the address.
  assign unused_operand_b = ^bus.operand_b_i[XLEN-1:CSR_ADDR_W];

  // Pointer, occupancy and empty-commit error state; reset and flush both clear it.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      commit_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
      commit_err <= bus.commit_i && empty;
    end
  end

  // Entry storage; contents need no reset because empty slots are never shown.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem[wr_ptr] <= new_entry;
  end

  assign bus.ready_o        = ready;
  assign bus.result_o       = bus.operand_a_i;
  assign bus.csr_valid_o    = !empty;
  assign bus.count_o        = count;
  assign bus.commit_err_o   = commit_err;
  assign bus.csr_addr_o     = empty ? '0 : head_entry.addr;
  assign bus.csr_trans_id_o = empty ? '0 : head_entry.trans_id;

endmodule

// File: tb/tb_csr_queue.sv
// tb_csr_queue: directed self-checking bench for csr_queue (DEPTH = 4).
module tb_csr_queue;
  import csr_queue_pkg::*;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int TIDW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [CSR_ADDR_W+TIDW-1:0] exp_q[$];

  csr_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .TRANS_ID_BITS(TIDW)) bus ();

  csr_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .TRANS_ID_BITS(TIDW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [11:0] a, input logic [TIDW-1:0] id);
    bus.valid_i     = 1'b1;
    bus.operand_b_i = XLEN'(a);
    bus.trans_id_i  = id;
    tick();
    bus.valid_i     = 1'b0;
  endtask

  task automatic drive_commit();
    bus.commit_i = 1'b1;
    tick();
    bus.commit_i = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", bus.ready_o); end
    n_checks++; if (bus.csr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", bus.csr_valid_o); end
    n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
    n_checks++; if (bus.csr_addr_o !== 12'h000) begin n_fail++; $display("FAIL reset_addr got=%0h exp=0", bus.csr_addr_o); end
    n_checks++; if (bus.csr_trans_id_o !== 3'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", bus.csr_trans_id_o); end
    n_checks++; if (bus.commit_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", bus.commit_err_o); end
  endtask

  task automatic test_fill_drain();
    logic [11:0] addrs [4];
    addrs = '{12'h300, 12'h305, 12'h341, 12'h7C0};
    for (int i = 0; i < 4; i++) begin
      drive_push(addrs[i], TIDW'(i));
      n_checks++; if (bus.count_o !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.count_o, i + 1); end
      n_checks++; if (bus.csr_addr_o !== 12'h300) begin n_fail++; $display("FAIL fill_head[%0d] got=%0h exp=300", i, bus.csr_addr_o); end
    end
    n_checks++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%0b exp=0", bus.ready_o); end
    drive_push(12'h100, 3'd4);
    n_checks++; if (bus.count_o !== 3'd4) begin n_fail++; $display("FAIL drop_count got=%0d exp=4", bus.count_o); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.csr_addr_o !== addrs[i]) begin n_fail++; $display("FAIL drain_addr[%0d] got=%0h exp=%0h", i, bus.csr_addr_o, addrs[i]); end
      n_checks++; if (bus.csr_trans_id_o !== TIDW'(i)) begin n_fail++; $display("FAIL drain_id[%0d] got=%0d exp=%0d", i, bus.csr_trans_id_o, i); end
      drive_commit();
      n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_ready[%0d] got=%0b exp=1", i, bus.ready_o); end
      n_checks++; if (bus.count_o !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, bus.count_o, 3 - i); end
    end
    n_checks++; if (bus.csr_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%0b exp=0", bus.csr_valid_o); end
    n_checks++; if (bus.csr_addr_o !== 12'h000) begin n_fail++; $display("FAIL drain_empty_addr got=%0h exp=0", bus.csr_addr_o); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [CSR_ADDR_W+TIDW-1:0] nxt;
    drive_push(12'h010, 3'd5);
    exp_q.push_back({12'h010, 3'd5});
    for (int i = 0; i < 6; i++) begin
      nxt = {12'h020 + 12'(i), 3'(i)};
      n_checks++; if ({bus.csr_addr_o, bus.csr_trans_id_o} !== exp_q[0]) begin n_fail++; $display("FAIL wrap_head[%0d] got=%0h exp=%0h", i, {bus.csr_addr_o, bus.csr_trans_id_o}, exp_q[0]); end
      bus.valid_i     = 1'b1;
      bus.commit_i    = 1'b1;
      bus.operand_b_i = XLEN'(nxt[14:3]);
      bus.trans_id_i  = nxt[2:0];
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(nxt);
      n_checks++; if (bus.count_o !== 3'd1) begin n_fail++; $display("FAIL wrap_count[%0d] got=%0d exp=1", i, bus.count_o); end
    end
    bus.valid_i  = 1'b0;
    bus.commit_i = 1'b0;
    n_checks++; if ({bus.csr_addr_o, bus.csr_trans_id_o} !== exp_q[0]) begin n_fail++; $display("FAIL wrap_last got=%0h exp=%0h", {bus.csr_addr_o, bus.csr_trans_id_o}, exp_q[0]); end
    drive_commit();
    void'(exp_q.pop_front());
    n_checks++; if (bus.csr_valid_o !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got=%0b exp=0", bus.csr_valid_o); end
  endtask

  task automatic test_full_push_commit();
    for (int i = 0; i < 4; i++) drive_push(12'h400 + 12'(i), TIDW'(i));
    bus.valid_i     = 1'b1;
    bus.commit_i    = 1'b1;
    bus.operand_b_i = XLEN'(12'h4FF);
    bus.trans_id_i  = 3'd7;
    tick();
    bus.valid_i  = 1'b0;
    bus.commit_i = 1'b0;
    n_checks++; if (bus.csr_addr_o !== 12'h401) begin n_fail++; $display("FAIL full_pc_head got=%0h exp=401", bus.csr_addr_o); end
`ifdef CSR_QUEUE_FULL_BYPASS_EN
    n_checks++; if (bus.count_o !== 3'd4) begin n_fail++; $display("FAIL full_pc_count got=%0d exp=4", bus.count_o); end
    for (int i = 0; i < 3; i++) drive_commit();
    n_checks++; if (bus.csr_addr_o !== 12'h4FF) begin n_fail++; $display("FAIL full_pc_tail got=%0h exp=4ff", bus.csr_addr_o); end
`else
    n_checks++; if (bus.count_o !== 3'd3) begin n_fail++; $display("FAIL full_pc_count got=%0d exp=3", bus.count_o); end
`endif
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL full_pc_flush got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_flush();
    drive_push(12'h111, 3'd1);
    drive_push(12'h222, 3'd2);
    drive_push(12'h333, 3'd3);
    bus.flush_i     = 1'b1;
    bus.valid_i     = 1'b1;
    bus.commit_i    = 1'b1;
    bus.operand_a_i = 64'hA;
    bus.operand_b_i = XLEN'(12'h444);
    bus.trans_id_i  = 3'd4;
    #1;
    n_checks++; if (bus.result_o !== 64'hA) begin n_fail++; $display("FAIL flush_result got=%0h exp=a", bus.result_o); end
    tick();
    bus.flush_i  = 1'b0;
    bus.valid_i  = 1'b0;
    bus.commit_i = 1'b0;
    n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", bus.count_o); end
    n_checks++; if (bus.csr_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%0b exp=0", bus.csr_valid_o); end
    n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%0b exp=1", bus.ready_o); end
    drive_push(12'h555, 3'd6);
    n_checks++; if (bus.count_o !== 3'd1) begin n_fail++; $display("FAIL flush_repush_count got=%0d exp=1", bus.count_o); end
    n_checks++; if (bus.csr_addr_o !== 12'h555) begin n_fail++; $display("FAIL flush_repush_head got=%0h exp=555", bus.csr_addr_o); end
    drive_commit();
  endtask

  task automatic test_result();
    logic [XLEN-1:0] vals [3];
    vals = '{64'h0, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      bus.operand_a_i = vals[i];
      #1;
      n_checks++; if (bus.result_o !== vals[i]) begin n_fail++; $display("FAIL result[%0d] got=%0h exp=%0h", i, bus.result_o, vals[i]); end
    end
  endtask

  task automatic test_empty_commit();
    drive_commit();
    n_checks++; if (bus.commit_err_o !== 1'b1) begin n_fail++; $display("FAIL empty_commit_err got=%0b exp=1", bus.commit_err_o); end
    n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL empty_commit_count got=%0d exp=0", bus.count_o); end
    tick();
    n_checks++; if (bus.commit_err_o !== 1'b0) begin n_fail++; $display("FAIL empty_commit_pulse got=%0b exp=0", bus.commit_err_o); end
  endtask

  task automatic test_reset_mid();
    drive_push(12'h7A1, 3'd2);
    drive_push(12'h7A2, 3'd3);
    n_checks++; if (bus.count_o !== 3'd2) begin n_fail++; $display("FAIL rst_mid_pre got=%0d exp=2", bus.count_o); end
    rst             = 1'b1;
    bus.valid_i     = 1'b1;
    bus.operand_b_i = XLEN'(12'h7A3);
    tick();
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL rst_mid_count got=%0d exp=0", bus.count_o); end
    n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%0b exp=1", bus.ready_o); end
    n_checks++; if (bus.csr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%0b exp=0", bus.csr_valid_o); end
    n_checks++; if (bus.csr_addr_o !== 12'h000) begin n_fail++; $display("FAIL rst_mid_addr got=%0h exp=0", bus.csr_addr_o); end
    n_checks++; if (bus.csr_trans_id_o !== 3'd0) begin n_fail++; $display("FAIL rst_mid_id got=%0d exp=0", bus.csr_trans_id_o); end
    n_checks++; if (bus.commit_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err got=%0b exp=0", bus.commit_err_o); end
  endtask

  // Sequence and final report
  initial begin
    bus.flush_i     = 1'b0;
    bus.valid_i     = 1'b0;
    bus.commit_i    = 1'b0;
    bus.operand_a_i = '0;
    bus.operand_b_i = '0;
    bus.trans_id_i  = '0;
    test_reset();
    test_fill_drain();
    test_back_to_back_wrap();
    test_full_push_commit();
    test_flush();
    test_result();
    test_empty_commit();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
